// File: rtl/muldiv_unit_pkg.sv
// Shared RISC-V defines: ALU op codes and the M-extension mul/div op encoding.
package muldiv_unit_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_SLL  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] sh;
  logic          ge;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    sh   = {hi_i, lo_i[XLEN-1]};
    ge   = (sh >= {1'b0, m_i});
    hi_o = '0;
    lo_o = '0;
    if (is_div_i) begin
      // Partial remainder stays below the divisor, so the XLEN-bit difference is exact.
      hi_o = ge ? (sh[XLEN-1:0] - m_i) : sh[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      {hi_o, lo_o} = {sum, lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle on magnitudes, sign fixup at the end.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  md_op_e          op_q, op_d, op_in;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_q, res_d;
  logic            neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            accept, sa, sb, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, hi_s, lo_s, fin;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (md_is_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .m_i      (m_q),
    .hi_o     (hi_s),
    .lo_o     (lo_s)
  );

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = out_valid ? res_q : '0;
  assign op_in      = md_op_e'(in_op);
  assign accept     = in_valid && in_ready && !flush;

  // Operand preparation for an incoming request.
  always_comb begin
    sa       = (op_in == MD_MULH) || (op_in == MD_MULHSU) || (op_in == MD_DIV) || (op_in == MD_REM);
    sb       = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
    a_neg    = sa && in_a[XLEN-1];
    b_neg    = sb && in_b[XLEN-1];
    a_mag    = a_neg ? (~in_a + 1'b1) : in_a;
    b_mag    = b_neg ? (~in_b + 1'b1) : in_b;
    div_zero = md_is_div(op_in) && (in_b == '0);
    ovf      = ((op_in == MD_DIV) || (op_in == MD_REM)) && (in_a == MIN_NEG) && (in_b == '1);
  end

  // Final result selection and sign correction from the last step's outputs.
  always_comb begin
    fin = '0;
    unique case (op_q)
      MD_MUL:                     fin = lo_s;
      MD_MULH, MD_MULHSU, MD_MULHU:
        // High half of -P: invert high word, carry in only if the low word is zero.
        fin = neg_q ? (~hi_s + XLEN'(lo_s == '0)) : hi_s;
      MD_DIV, MD_DIVU:            fin = neg_q ? (~lo_s + 1'b1) : lo_s;
      MD_REM, MD_REMU:            fin = neg_q ? (~hi_s + 1'b1) : hi_s;
      default:                    fin = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    res_d   = res_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op_in;
          if (div_zero || ovf) begin
            state_d = S_DONE;
            cnt_d   = '0;
            if (div_zero) res_d = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : in_a;
            else          res_d = (op_in == MD_DIV) ? in_a : '0;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(XLEN);
            hi_d    = '0;
            lo_d    = md_is_div(op_in) ? a_mag : b_mag;
            m_d     = md_is_div(op_in) ? b_mag : a_mag;
            unique case (op_in)
              MD_MULH, MD_DIV: neg_d = a_neg ^ b_neg;
              MD_MULHSU, MD_REM: neg_d = a_neg;
              default: neg_d = 1'b0;
            endcase
          end
        end
      end
      S_CALC: begin
        hi_d  = hi_s;
        lo_d  = lo_s;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          res_d   = fin;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= MD_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  unit can accept; high only in IDLE.
REQ-007 in_op  in  3  md_op_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 in_a  in  XLEN  rs1 operand (multiplicand/dividend).
REQ-009 in_b  in  XLEN  rs2 operand (multiplier/divisor).
REQ-010 flush  in  1  abort in-flight operation (pipeline kill).
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_result  out  XLEN  result.
REQ-014 busy  out  1  high in CALC or DONE.

Function
REQ-015 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-016 Accept = in_valid && in_ready; on accept, latch op, operands, signs; IDLE->CALC, counter loaded with XLEN.
REQ-017 CALC: one radix-2 step per cycle (shift-add for MUL*, restoring shift-subtract for DIV*/REM*) on magnitudes; counter decrements; at counter==1 step, CALC->DONE.
REQ-018 Latency: out_valid SHALL rise exactly XLEN+1 edges after accepting edge (XLEN=32: 33).
REQ-019 Signed ops: operands converted to magnitude at accept; result negated at CALC->DONE per RISC-V sign rules (MULH both signed, MULHSU rs1 signed only, REM sign follows dividend).
REQ-020 MUL returns low XLEN bits of 2*XLEN product; MULH* return high XLEN bits.
REQ-021 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> in_a; SHALL go IDLE->DONE directly, out_valid 1 edge after accept.
REQ-022 Signed overflow (in_a = most-negative, in_b = -1, DIV/REM): DIV -> in_a, REM -> 0; same 1-edge path as REQ-021.
REQ-023 DONE: out_valid=1, out_result stable; on out_ready DONE->IDLE; out_result SHALL hold while out_valid && !out_ready.
REQ-024 No new accept in the DONE->IDLE cycle (in_ready low in DONE); back-to-back throughput one op per XLEN+2 cycles.
REQ-025 flush in any state: next edge -> IDLE, out_valid=0, no result emitted; flush wins over simultaneous accept or out_ready.
REQ-026 out_result SHALL be 0 whenever out_valid=0.

Reset
REQ-027 rst_n low: state IDLE, in_ready=1 after release, out_valid=0, busy=0, out_result=0, counter=0, datapath registers 0, immediately and asynchronously.
REQ-028 Reset mid-CALC or mid-DONE SHALL discard the operation with no result emitted.

Structure
REQ-029 md_op_e enum and MD_* op encodings SHALL live in the shared riscv defines package beside ALU_OP_* codes.
REQ-030 FSM state enum local to module.
REQ-031 One sub-module natural: muldiv_step (combinational one-bit add/subtract step, parametrised XLEN); FSM and registers stay in muldiv_unit.

Verification
REQ-032 MUL 7 x 6, XLEN=32 -> out_result=42, out_valid exactly 33 edges after accept.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; each out_valid 1 edge after accept.
REQ-036 out_ready held low 10 cycles in DONE -> out_result constant, in_ready low; out_ready high -> IDLE next edge.
REQ-037 flush at CALC cycle 5, and rst_n low at CALC cycle 10 -> IDLE, out_valid never asserted, next op 3 x 3 returns 9.
